// File: rtl/spi_responder.sv
// SPI mode-0 responder: oversamples the SPI pins in the system clock domain,
// receives one WIDTH-bit word per select window and returns a shadowed word.
module spi_responder #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_100mhz,
   input  logic             sys_rst,
   input  logic             spi_clk,
   input  logic             spi_ss,
   input  logic             spi_mosi,
   output logic             spi_miso,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_load,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             busy,
   output logic             frame_err
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int FW = $clog2(SYNC_STAGES + 1);
   localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
   localparam logic [FW-1:0] FILL_DONE = FW'(SYNC_STAGES);

   typedef enum logic [1:0] {IDLE, SHIFT, WAIT_DESELECT} state_t;

   state_t           state;
   logic [SYNC_STAGES-1:0] clk_sync, ss_sync, mosi_sync;
   logic             clk_d, ss_d;
   logic [FW-1:0]    fill_cnt;
   logic             armed;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] rx_shift, tx_shift, shadow;

   logic clk_s, ss_s, mosi_s;
   logic clk_rise, clk_fall, ss_rise, ss_fall;

   assign clk_s    = clk_sync[SYNC_STAGES-1];
   assign ss_s     = ss_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign clk_rise = clk_s & ~clk_d;
   assign clk_fall = ~clk_s & clk_d;
   assign ss_rise  = ss_s & ~ss_d;
   // A fall only counts once a genuine high select has been seen since reset,
   // so a select already low at reset release cannot start a frame.
   assign ss_fall  = ~ss_s & ss_d & armed;

   assign tx_ready = (state == IDLE) && !ss_fall;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk_100mhz) begin
      if (sys_rst) begin
         clk_sync  <= '0;
         ss_sync   <= '1;
         mosi_sync <= '0;
         clk_d     <= 1'b0;
         ss_d      <= 1'b1;
         fill_cnt  <= '0;
         armed     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
         clk_sync[0]  <= spi_clk;
         ss_sync[0]   <= spi_ss;
         mosi_sync[0] <= spi_mosi;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            clk_sync[i]  <= clk_sync[i-1];
            ss_sync[i]   <= ss_sync[i-1];
            mosi_sync[i] <= mosi_sync[i-1];
         end
         clk_d <= clk_s;
         ss_d  <= ss_s;
         if (fill_cnt != FILL_DONE) fill_cnt <= fill_cnt + FW'(1);
         else if (ss_s)             armed    <= 1'b1;
      end
   end

   always_ff @(posedge clk_100mhz) begin
      if (sys_rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         rx_shift  <= '0;
         tx_shift  <= '0;
         shadow    <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         spi_miso  <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         if (tx_load && tx_ready) shadow <= tx_data;

         case (state)
            IDLE: begin
               spi_miso <= 1'b0;
               if (ss_fall) begin
                  state    <= SHIFT;
                  bit_cnt  <= '0;
                  tx_shift <= shadow;
                  spi_miso <= shadow[WIDTH-1];
               end
            end

            SHIFT: begin
               // Deselect wins over a simultaneous clock rise; that bit is dropped.
               if (ss_rise) begin
                  frame_err <= 1'b1;
                  spi_miso  <= 1'b0;
                  state     <= IDLE;
               end else if (clk_rise) begin
                  rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};
                  bit_cnt  <= bit_cnt + CW'(1);
                  if (bit_cnt == LAST_BIT) begin
                     rx_data  <= {rx_shift[WIDTH-2:0], mosi_s};
                     rx_valid <= 1'b1;
                     spi_miso <= 1'b0;
                     state    <= WAIT_DESELECT;
                  end
               end else if (clk_fall && bit_cnt != '0) begin
                  tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                  spi_miso <= tx_shift[WIDTH-2];
               end
            end

            WAIT_DESELECT: begin
               spi_miso <= 1'b0;
               if (ss_rise) state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: acts as a mode-0 SPI initiator and compares every
// frame against a word-level model of what the responder should return.
module tb_spi_responder;

   localparam int WIDTH = 16;

   logic             clk_100mhz = 1'b0;
   logic             sys_rst;
   logic             spi_clk, spi_ss, spi_mosi;
   logic             spi_miso;
   logic [WIDTH-1:0] tx_data;
   logic             tx_load;
   logic             tx_ready;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid, busy, frame_err;

   int checks = 0;
   int errors = 0;
   int rv_cnt = 0;
   int fe_cnt = 0;

   // Word-level model: what was loaded, and what the last good frame carried.
   logic [WIDTH-1:0] shadow_m = '0;
   logic [WIDTH-1:0] rx_m     = '0;

   spi_responder #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
      .clk_100mhz(clk_100mhz),
      .sys_rst   (sys_rst),
      .spi_clk   (spi_clk),
      .spi_ss    (spi_ss),
      .spi_mosi  (spi_mosi),
      .spi_miso  (spi_miso),
      .tx_data   (tx_data),
      .tx_load   (tx_load),
      .tx_ready  (tx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .busy      (busy),
      .frame_err (frame_err)
   );

   always #5 clk_100mhz = ~clk_100mhz;

   always @(negedge clk_100mhz) begin
      if (rx_valid === 1'b1)  rv_cnt++;
      if (frame_err === 1'b1) fe_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk_100mhz);
   endtask

   task automatic load_word(input logic [WIDTH-1:0] w);
      tx_data = w;
      tx_load = 1'b1;
      check("load_ready", 32'(tx_ready), 32'd1);
      wait_cyc(1);
      tx_load  = 1'b0;
      shadow_m = w;
   endtask

   // Clocks nbits bits MSB first with a 10-cycle spi_clk period; miso is
   // captured at each rising edge as a real initiator would.
   task automatic shift_bits(input logic [31:0] bits, input int nbits, input bit bad_load,
                             output logic [31:0] miso_w);
      miso_w = '0;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = bits[nbits-1-i];
         wait_cyc(5);
         spi_clk = 1'b1;
         miso_w  = {miso_w[30:0], spi_miso};
         if (bad_load && i == 2) begin
            tx_data = ~shadow_m;
            tx_load = 1'b1;
            wait_cyc(1);
            tx_load = 1'b0;
            wait_cyc(4);
         end else begin
            wait_cyc(5);
         end
         spi_clk = 1'b0;
      end
   endtask

   task automatic run_frame(input string tag, input logic [31:0] bits_in, input int nbits,
                            input bit bad_load);
      logic [31:0] bits, miso_w, exp_miso;
      int rv0, fe0, exp_rv, exp_fe;
      bits = (nbits >= 32) ? bits_in : (bits_in & ((32'd1 << nbits) - 32'd1));
      rv0  = rv_cnt;
      fe0  = fe_cnt;
      spi_ss = 1'b0;
      wait_cyc(10);
      check({tag, "/busy_in"},  32'(busy),     32'd1);
      check({tag, "/ready_in"}, 32'(tx_ready), 32'd0);
      shift_bits(bits, nbits, bad_load, miso_w);
      wait_cyc(10);
      spi_ss = 1'b1;
      wait_cyc(10);

      if (nbits >= WIDTH) begin
         exp_miso = 32'(shadow_m) << (nbits - WIDTH);
         rx_m     = WIDTH'(bits >> (nbits - WIDTH));
         exp_rv   = 1;
         exp_fe   = 0;
      end else begin
         exp_miso = 32'(shadow_m) >> (WIDTH - nbits);
         exp_rv   = 0;
         exp_fe   = 1;
      end
      check({tag, "/miso"},      miso_w,           exp_miso);
      check({tag, "/rx_data"},   32'(rx_data),     32'(rx_m));
      check({tag, "/rx_valid"},  32'(rv_cnt - rv0), 32'(exp_rv));
      check({tag, "/frame_err"}, 32'(fe_cnt - fe0), 32'(exp_fe));
      check({tag, "/busy_out"},  32'(busy),         32'd0);
      check({tag, "/miso_idle"}, 32'(spi_miso),     32'd0);
   endtask

   initial begin
      logic [31:0] mw;
      int rv0, fe0;

      sys_rst  = 1'b1;
      spi_clk  = 1'b0;
      spi_ss   = 1'b1;
      spi_mosi = 1'b0;
      tx_load  = 1'b0;
      tx_data  = '0;
      wait_cyc(5);
      sys_rst = 1'b0;
      wait_cyc(2);

      check("rst/tx_ready",  32'(tx_ready),  32'd1);
      check("rst/busy",      32'(busy),      32'd0);
      check("rst/miso",      32'(spi_miso),  32'd0);
      check("rst/rx_data",   32'(rx_data),   32'd0);
      check("rst/rx_valid",  32'(rx_valid),  32'd0);
      check("rst/frame_err", 32'(frame_err), 32'd0);

      wait_cyc(100);
      check("idle/rx_valid",  32'(rv_cnt),   32'd0);
      check("idle/frame_err", 32'(fe_cnt),   32'd0);
      check("idle/tx_ready",  32'(tx_ready), 32'd1);
      check("idle/busy",      32'(busy),     32'd0);

      run_frame("a201", 32'hA201, 16, 1'b0);

      load_word(16'h5A3C);
      run_frame("tx1", $urandom, 16, 1'b0);
      run_frame("tx2", $urandom, 16, 1'b0);

      run_frame("a201b", 32'hA201, 16, 1'b0);
      run_frame("abort", $urandom, 7, 1'b0);

      run_frame("beef20", 32'hBEEFF, 20, 1'b0);

      run_frame("busyload", $urandom, 16, 1'b1);
      run_frame("afterbusy", $urandom, 16, 1'b0);

      for (int k = 0; k < 8; k++) begin
         if ($urandom_range(0, 1) == 1) load_word(WIDTH'($urandom));
         run_frame("rand", $urandom, int'($urandom_range(1, 20)), 1'b0);
      end

      // Reset in the middle of a frame with select held low throughout.
      spi_ss = 1'b0;
      wait_cyc(10);
      shift_bits($urandom, 8, 1'b0, mw);
      rv0 = rv_cnt;
      fe0 = fe_cnt;
      sys_rst = 1'b1;
      wait_cyc(3);
      sys_rst  = 1'b0;
      shadow_m = '0;
      rx_m     = '0;
      wait_cyc(10);
      check("midrst/busy",     32'(busy),     32'd0);
      check("midrst/tx_ready", 32'(tx_ready), 32'd1);
      check("midrst/rx_data",  32'(rx_data),  32'd0);
      shift_bits($urandom, 16, 1'b0, mw);
      wait_cyc(10);
      check("midrst/miso",      mw,                 32'd0);
      check("midrst/busy2",     32'(busy),          32'd0);
      check("midrst/rx_valid",  32'(rv_cnt - rv0),  32'd0);
      check("midrst/frame_err", 32'(fe_cnt - fe0),  32'd0);
      check("midrst/rx_data2",  32'(rx_data),       32'd0);
      spi_ss = 1'b1;
      wait_cyc(10);
      run_frame("1234", 32'h1234, 16, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_responder.md
SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on posedge clk_100mhz.
REQ-002 Parameter WIDTH, default 16, SHALL set bits per frame.
REQ-003 Parameter SYNC_STAGES, default 2, SHALL set flops per input synchronizer.
REQ-004 clk_100mhz  in  1  system clock.
REQ-005 sys_rst  in  1  synchronous active-high reset.
REQ-006 spi_clk  in  1  asynchronous SPI clock from initiator (mode 0, idle low).
REQ-007 spi_ss  in  1  asynchronous active-low select.
REQ-008 spi_mosi  in  1  asynchronous initiator data, MSB first.
REQ-009 spi_miso  out  1  responder data, MSB first.
REQ-010 tx_data  in  WIDTH  word to return in the next frame.
REQ-011 tx_load  in  1  capture tx_data into the shadow register when tx_ready=1.
REQ-012 tx_ready  out  1  shadow register may be loaded.
REQ-013 rx_data  out  WIDTH  last complete received word.
REQ-014 rx_valid  out  1  one-cycle pulse; rx_data is new.
REQ-015 busy  out  1  frame in progress (state not IDLE).
REQ-016 frame_err  out  1  one-cycle pulse; frame aborted short.

Function
REQ-017 spi_clk, spi_ss and spi_mosi SHALL each pass through SYNC_STAGES flops; one extra registered copy of synced clk/ss SHALL provide edge detection.
REQ-018 A pin edge SHALL be detected exactly SYNC_STAGES+1 cycles after it is sampled; the initiator SHALL hold spi_clk high and low for >=4 system cycles each.
REQ-019 FSM states: IDLE, SHIFT, WAIT_DESELECT.
REQ-020 IDLE->SHIFT on detected ss fall: bit counter=0; tx shift register loaded from shadow; spi_miso=shadow MSB.
REQ-021 In SHIFT, each detected spi_clk rise SHALL shift synced mosi into the rx shift register LSB and increment the counter.
REQ-022 In SHIFT, each detected spi_clk fall SHALL shift the tx register left one bit, driving the next bit on spi_miso; a fall before the first rise SHALL be ignored.
REQ-023 On the WIDTH-th rise, rx_data SHALL update and rx_valid SHALL pulse on the following cycle; state->WAIT_DESELECT.
REQ-024 In WAIT_DESELECT, further spi_clk edges SHALL be ignored, spi_miso=0, no extra rx_valid; detected ss rise->IDLE.
REQ-025 Detected ss rise in SHIFT with counter<WIDTH: frame_err SHALL pulse one cycle, rx_data unchanged, no rx_valid, ->IDLE.
REQ-026 Rise and ss rise detected in the same cycle: ss rise SHALL win; the bit SHALL be discarded.
REQ-027 spi_miso SHALL be 0 whenever state is IDLE.
REQ-028 tx_ready = (state==IDLE) and no ss fall detected this cycle; tx_load while tx_ready=0 SHALL be ignored.
REQ-029 Shadow register SHALL keep its value across frames until reloaded; the same word SHALL be resent each frame.
REQ-030 busy SHALL be 1 in SHIFT and WAIT_DESELECT, else 0.

Reset
REQ-031 sys_rst SHALL force: state IDLE, counters 0, rx_data 0, shadow 0, rx_valid 0, frame_err 0, spi_miso 0, busy 0, tx_ready 1.
REQ-032 Synchronizer and edge flops SHALL reset to clk=0, ss=1, mosi=0 so that no edge is detected on release.
REQ-033 Reset mid-frame SHALL abandon the frame without rx_valid or frame_err; if ss is still low at release, the block SHALL wait for an ss rise, then a fresh fall, before shifting.

Verification
REQ-034 Reset, then idle pins -> tx_ready=1, busy=0, spi_miso=0, no rx_valid/frame_err for 100 cycles.
REQ-035 Initiator sends 0xA201, spi_clk period 10 cycles -> rx_data=0xA201, exactly one rx_valid pulse, busy=0 after ss high.
REQ-036 tx_load 0x5A3C in IDLE, then 16-bit frame -> initiator samples 0x5A3C on spi_miso rises; second frame without load also returns 0x5A3C.
REQ-037 ss raised after 7 clocks, prior rx_data=0xA201 -> one frame_err pulse, rx_data stays 0xA201, no rx_valid.
REQ-038 20 clocks in one select window, MOSI 0xBEEF then 0xF -> rx_data=0xBEEF, single rx_valid, spi_miso=0 after bit 16.
REQ-039 sys_rst after 8 bits with ss held low -> ignored until ss cycles high/low; next frame 0x1234 received correctly.
